dmem_responder: RTL
===================

# dmem_responder

Memory-side responder for the data-cache refill/writeback port: accepts single-word read and write requests from the dcache (`rden`/`wren` with separate read and write addresses) and completes each after a fixed, parameterised access latency. It replaces the zero-wait data memory behind the cache, so the cache's miss handling sees realistic memory timing. It signals completion with a one-cycle `data_valid` pulse and holds off new requests with `busy`.

## Interface
- `DEPTH`, 16384 — storage size in 32-bit words; power of two, at most 16384.
- `LATENCY`, 4 — cycles from request acceptance to completion; range 1 to 15.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `rden`  in  1  — read request.
- `wren`  in  1  — write request.
- `rdaddress`  in  16  — read byte address; word index is `rdaddress[15:2]`.
- `wraddress`  in  16  — write byte address; word index is `wraddress[15:2]`.
- `write_data`  in  32  — write word.
- `read_data`  out  32  — read word; holds its value between completions.
- `data_valid`  out  1  — one-cycle completion pulse.
- `busy`  out  1  — a transaction is in flight; requests are ignored.
- `resp_err`  out  1  — out-of-range access; present only with `DMEM_ERR_EN`.

## Operation
- States: IDLE, WAIT, DONE. In IDLE and DONE, the block accepts a request when `rden|wren` is high. In WAIT, requests are ignored and not queued. The initiator must hold off while `busy` is high.
- On acceptance, the block captures `rdaddress`, `wraddress`, `write_data` and the request type into registers and loads the latency counter with `LATENCY-1`.
- WAIT decrements the counter each cycle. When the count reaches 0, the block moves to DONE.
- When `LATENCY` is 1, the block goes straight from acceptance to DONE.
- At the transition into DONE:
  - Write: the captured word is committed to the captured word index.
  - Read: `read_data` is loaded from the captured read index.
- If `rden` and `wren` are accepted together, they form one combined transaction. The write commits first, so if the indices match, `read_data` returns the newly written word.
- A write-only transaction still pulses `data_valid`. In that case `read_data` is unchanged.
- From DONE, the block returns to IDLE, or re-enters WAIT or DONE if a new request is accepted in that cycle.
- Storage contents are not reset.

## Timing
- Reset values: `read_data`=0, `data_valid`=0, `busy`=0, `resp_err`=0, state=IDLE, counter=0.
- A request accepted in cycle T gives `data_valid`=1 in cycle T+`LATENCY` only.
- `busy`=1 in cycles T+1 through T+`LATENCY`-1. It is 0 in the `data_valid` cycle, which allows back-to-back transactions every `LATENCY` cycles.
- With `LATENCY`=1, `busy` never asserts and the block sustains one transaction per cycle.
- Outputs are registered. There is no combinational path from inputs to outputs.
- Reset asserted mid-transaction:
  - The transaction is aborted and the write is not committed.
  - `data_valid` is not pulsed.
  - All outputs return to their reset values asynchronously.

## Configuration
- `DMEM_ERR_EN` defined:
  - A word index at or above `DEPTH` (using the captured address) is out of range.
  - An out-of-range write is dropped.
  - An out-of-range read returns 0.
  - `resp_err` is asserted together with `data_valid` for that one cycle.
- `DMEM_ERR_EN` undefined:
  - The `resp_err` port and its logic are absent.
  - The index is truncated to `$clog2(DEPTH)` bits, so addresses wrap modulo `DEPTH`.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE, WAIT, DONE);
  - `DMEM_WORD_W`=32 and `DMEM_ADDR_W`=16;
  - the counter width constant (4 bits).
- Sub-module `dmem_array`: word storage with one synchronous write port and one synchronous read port, with write-before-read on a same-index access. The FSM, capture registers and counter stay in `dmem_responder`.

## Test plan
- Reset, then write 0xDEADBEEF to 0x0010 with `LATENCY`=4, accepted at T → `busy` high T+1..T+3, `data_valid` at T+4, `read_data` stays 0.
- Read 0x0010 after that write → `data_valid` 4 cycles later with `read_data`=0xDEADBEEF.
- Combined `rden`+`wren` to 0x0020 with data 0x12345678 → single `data_valid`, `read_data`=0x12345678.
- Request pulsed during `busy` → ignored: no second `data_valid`, and storage is unchanged when read back.
- Reset asserted at T+2 of a write of 0xCAFEF00D to 0x0030 → no `data_valid`; a later read of 0x0030 does not return 0xCAFEF00D (after preloading 0x0). Also, `LATENCY`=1 back-to-back reads of 0x0010 and 0x0020 → `data_valid` on consecutive cycles.
- With `DMEM_ERR_EN` and `DEPTH`=1024, read 0x1000 → `read_data`=0 and `resp_err`=1 for one cycle. Without `DMEM_ERR_EN`, the same read returns the word at 0x0000.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
// Optional out-of-range checking is enabled with the DMEM_ERR_EN macro.
package dmem_pkg;
   localparam int DMEM_WORD_W = 32;
   localparam int DMEM_ADDR_W = 16;
   localparam int DMEM_CNT_W  = 4;
   localparam int DMEM_IDX_W  = DMEM_ADDR_W - 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

   function automatic logic [DMEM_IDX_W-1:0] word_idx(input logic [DMEM_ADDR_W-1:0] addr);
      return addr[DMEM_ADDR_W-1:2];
   endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the dcache (master) and the memory responder (slave).
// resp_err exists only when DMEM_ERR_EN is defined.
interface dmem_responder_if;
   import dmem_pkg::*;

   logic                   rden;
   logic                   wren;
   logic [DMEM_ADDR_W-1:0] rdaddress;
   logic [DMEM_ADDR_W-1:0] wraddress;
   logic [DMEM_WORD_W-1:0] write_data;
   logic [DMEM_WORD_W-1:0] read_data;
   logic                   data_valid;
   logic                   busy;
`ifdef DMEM_ERR_EN
   logic                   resp_err;

   modport master (output rden, wren, rdaddress, wraddress, write_data,
                   input  read_data, data_valid, busy, resp_err);
   modport slave  (input  rden, wren, rdaddress, wraddress, write_data,
                   output read_data, data_valid, busy, resp_err);
`else
   modport master (output rden, wren, rdaddress, wraddress, write_data,
                   input  read_data, data_valid, busy);
   modport slave  (input  rden, wren, rdaddress, wraddress, write_data,
                   output read_data, data_valid, busy);
`endif
endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one synchronous read port, write-before-read
// on a same-index access. Storage is not reset; only the read register is.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 16384
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DMEM_WORD_W-1:0]   wdata,
   input  logic                     re,
   input  logic                     rzero,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DMEM_WORD_W-1:0]   rdata
);
   logic [DMEM_WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // rdata only moves on a read, so it holds between completions
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rdata <= '0;
      else if (re) begin
         if (rzero)
            rdata <= '0;
         else if (we && (waddr == raddr))
            rdata <= wdata;
         else
            rdata <= mem[raddr];
      end
   end
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency memory responder for the dcache refill/writeback port.
// Define DMEM_ERR_EN to flag and suppress out-of-range accesses instead of wrapping.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 16384,
   parameter int LATENCY = 4
) (
   input  logic            clk,
   input  logic            rst,
   dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   dmem_state_e            state, state_n;
   logic [DMEM_CNT_W-1:0]  cnt, cnt_n;
   logic                   cap_rd, cap_wr;
   logic [DMEM_IDX_W-1:0]  cap_ridx, cap_widx;
   logic [DMEM_WORD_W-1:0] cap_wd;
   logic                   dv_q, busy_q;
   logic                   accept, enter_done;
   logic                   t_rd, t_wr;
   logic [DMEM_IDX_W-1:0]  t_ridx, t_widx;
   logic [DMEM_WORD_W-1:0] t_wd;
   logic                   rd_oob, wr_oob;
   logic                   mem_we, mem_re;
   logic [DMEM_WORD_W-1:0] rdata;
   logic                   unused;

   assign accept = (state != WAIT) && (bus.rden || bus.wren);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE, DONE: begin
            state_n = IDLE;
            if (accept) begin
               if (LATENCY == 1)
                  state_n = DONE;
               else begin
                  state_n = WAIT;
                  cnt_n   = DMEM_CNT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt <= DMEM_CNT_W'(1)) begin
               state_n = DONE;
               cnt_n   = '0;
            end else
               cnt_n = cnt - DMEM_CNT_W'(1);
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign enter_done = (state_n == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         dv_q     <= 1'b0;
         busy_q   <= 1'b0;
         cap_rd   <= 1'b0;
         cap_wr   <= 1'b0;
         cap_ridx <= '0;
         cap_widx <= '0;
         cap_wd   <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         dv_q   <= enter_done;
         busy_q <= (state_n == WAIT);
         if (accept) begin
            cap_rd   <= bus.rden;
            cap_wr   <= bus.wren;
            cap_ridx <= word_idx(bus.rdaddress);
            cap_widx <= word_idx(bus.wraddress);
            cap_wd   <= bus.write_data;
         end
      end
   end

   // Single-cycle latency commits on the accepting edge, before capture lands
   assign t_rd   = (LATENCY == 1) ? bus.rden                 : cap_rd;
   assign t_wr   = (LATENCY == 1) ? bus.wren                 : cap_wr;
   assign t_ridx = (LATENCY == 1) ? word_idx(bus.rdaddress)  : cap_ridx;
   assign t_widx = (LATENCY == 1) ? word_idx(bus.wraddress)  : cap_widx;
   assign t_wd   = (LATENCY == 1) ? bus.write_data           : cap_wd;

`ifdef DMEM_ERR_EN
   logic err_q;

   assign rd_oob = {1'b0, t_ridx} >= (DMEM_IDX_W+1)'(DEPTH);
   assign wr_oob = {1'b0, t_widx} >= (DMEM_IDX_W+1)'(DEPTH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= enter_done && ((t_rd && rd_oob) || (t_wr && wr_oob));
   end

   assign bus.resp_err = err_q;
`else
   assign rd_oob = 1'b0;
   assign wr_oob = 1'b0;
`endif

   // rst gate keeps a request seen during reset from reaching storage
   assign mem_we = enter_done && t_wr && !wr_oob && rst;
   assign mem_re = enter_done && t_rd;

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (t_widx[AW-1:0]),
      .wdata (t_wd),
      .re    (mem_re),
      .rzero (rd_oob),
      .raddr (t_ridx[AW-1:0]),
      .rdata (rdata)
   );

   assign bus.read_data  = rdata;
   assign bus.data_valid = dv_q;
   assign bus.busy       = busy_q;
   assign unused         = ^{bus.rdaddress[1:0], bus.wraddress[1:0]};
endmodule
